// File: rtl/param_register_file.sv
// Parametrised register file with write-to-read bypass, per-register busy scoreboard,
// write-protected registers and an optional registered read stage.
module param_register_file #(
  parameter int unsigned                DATA_W    = 32,
  parameter int unsigned                ADDR_W    = 4,
  parameter int unsigned                NUM_RD    = 2,
  parameter logic [(2**ADDR_W)-1:0]     PROT_MASK = 16'hC000,
  parameter bit                         BYPASS    = 1'b1,
  parameter bit                         REG_RD    = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_RD*ADDR_W-1:0]    rdAddr,
  output logic [NUM_RD*DATA_W-1:0]    rdData,
  output logic [NUM_RD-1:0]           rdBusy,
  input  logic                        wrEn,
  input  logic [ADDR_W-1:0]           wrAddr,
  input  logic [DATA_W-1:0]           wrData,
  input  logic                        claimEn,
  input  logic [ADDR_W-1:0]           claimAddr,
  output logic [(2**ADDR_W)-1:0]      busyVec,
  output logic                        wrProtErr
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        regs_q [DEPTH];
  logic [DEPTH-1:0]         busy_q, busy_d;
  logic                     prot_err_q, prot_err_d;
  logic                     wr_ok_c, claim_ok_c;
  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_busy_c;

  // Qualify writes/claims against the protection mask; a claim overrides a same-address write clear.
  always_comb begin
    wr_ok_c    = wrEn && !PROT_MASK[wrAddr];
    claim_ok_c = claimEn && !PROT_MASK[claimAddr];
    prot_err_d = wrEn && PROT_MASK[wrAddr];
    busy_d     = busy_q;
    if (wr_ok_c) begin
      busy_d[wrAddr] = 1'b0;
    end
    if (claim_ok_c) begin
      busy_d[claimAddr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q     <= '0;
      prot_err_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      prot_err_q <= prot_err_d;
    end
  end

  // Storage resets to its own index so software sees a recognisable pattern.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        regs_q[k] <= DATA_W'(k);
      end
    end else if (wr_ok_c) begin
      regs_q[wrAddr] <= wrData;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr_c;
    logic              hit_c;
    assign addr_c = rdAddr[p*ADDR_W +: ADDR_W];
    assign hit_c  = BYPASS && wr_ok_c && (wrAddr == addr_c);
    assign rd_data_c[p*DATA_W +: DATA_W] = hit_c ? wrData : regs_q[addr_c];
    assign rd_busy_c[p] = busy_q[addr_c] && !hit_c;
  end

  if (REG_RD) begin : g_reg_rd
    logic [NUM_RD*DATA_W-1:0] rd_data_q;
    logic [NUM_RD-1:0]        rd_busy_q;
    always_ff @(posedge clk) begin
      if (!reset) begin
        rd_data_q <= '0;
        rd_busy_q <= '0;
      end else begin
        rd_data_q <= rd_data_c;
        rd_busy_q <= rd_busy_c;
      end
    end
    assign rdData = rd_data_q;
    assign rdBusy = rd_busy_q;
  end else begin : g_comb_rd
    assign rdData = rd_data_c;
    assign rdBusy = rd_busy_c;
  end

  assign busyVec   = busy_q;
  assign wrProtErr = prot_err_q;

endmodule

// File: tb/tb_param_register_file.sv
// Randomised + directed bench: three DUT flavours (bypass, no bypass, registered read)
// share one stimulus stream and are compared against an array-based reference model.
module tb_param_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rdAddr;
  logic        wrEn;
  logic [3:0]  wrAddr;
  logic [31:0] wrData;
  logic        claimEn;
  logic [3:0]  claimAddr;

  logic [63:0] rdData_a, rdData_b, rdData_c;
  logic [1:0]  rdBusy_a, rdBusy_b, rdBusy_c;
  logic [15:0] busyVec_a, busyVec_b, busyVec_c;
  logic        wrProtErr_a, wrProtErr_b, wrProtErr_c;

  always #5 clk = ~clk;

  param_register_file #(.BYPASS(1'b1), .REG_RD(1'b0)) u_a (
    .clk(clk), .reset(reset), .rdAddr(rdAddr), .rdData(rdData_a), .rdBusy(rdBusy_a),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .claimEn(claimEn), .claimAddr(claimAddr),
    .busyVec(busyVec_a), .wrProtErr(wrProtErr_a));

  param_register_file #(.BYPASS(1'b0), .REG_RD(1'b0)) u_b (
    .clk(clk), .reset(reset), .rdAddr(rdAddr), .rdData(rdData_b), .rdBusy(rdBusy_b),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .claimEn(claimEn), .claimAddr(claimAddr),
    .busyVec(busyVec_b), .wrProtErr(wrProtErr_b));

  param_register_file #(.BYPASS(1'b1), .REG_RD(1'b1)) u_c (
    .clk(clk), .reset(reset), .rdAddr(rdAddr), .rdData(rdData_c), .rdBusy(rdBusy_c),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .claimEn(claimEn), .claimAddr(claimAddr),
    .busyVec(busyVec_c), .wrProtErr(wrProtErr_c));

  localparam logic [15:0] PROT = 16'hC000;

  // Reference state
  logic [31:0] m_regs [16];
  logic [15:0] m_busy;
  logic        m_err;
  logic [31:0] c_data [2];
  logic        c_busy [2];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void view(input bit byp, input int p, output logic [31:0] d, output logic b);
    logic [3:0] a;
    logic       hit;
    a   = rdAddr[p*4 +: 4];
    hit = byp && wrEn && !PROT[wrAddr] && (wrAddr == a);
    d   = hit ? wrData : m_regs[a];
    b   = m_busy[a] && !hit;
  endfunction

  task automatic drive(input logic rst, input logic [3:0] ra1, input logic [3:0] ra0,
                       input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic ce, input logic [3:0] ca);
    @(negedge clk);
    reset = rst; rdAddr = {ra1, ra0};
    wrEn = we; wrAddr = wa; wrData = wd;
    claimEn = ce; claimAddr = ca;
    #1;
  endtask

  task automatic check_all();
    logic [31:0] d;
    logic        b;
    for (int p = 0; p < 2; p++) begin
      view(1'b1, p, d, b);
      check($sformatf("a_data%0d", p), rdData_a[p*32 +: 32], d);
      check($sformatf("a_busy%0d", p), 32'(rdBusy_a[p]), 32'(b));
      view(1'b0, p, d, b);
      check($sformatf("b_data%0d", p), rdData_b[p*32 +: 32], d);
      check($sformatf("b_busy%0d", p), 32'(rdBusy_b[p]), 32'(b));
      check($sformatf("c_data%0d", p), rdData_c[p*32 +: 32], c_data[p]);
      check($sformatf("c_busy%0d", p), 32'(rdBusy_c[p]), 32'(c_busy[p]));
    end
    check("a_busyvec", 32'(busyVec_a), 32'(m_busy));
    check("b_busyvec", 32'(busyVec_b), 32'(m_busy));
    check("c_busyvec", 32'(busyVec_c), 32'(m_busy));
    check("a_proterr", 32'(wrProtErr_a), 32'(m_err));
    check("c_proterr", 32'(wrProtErr_c), 32'(m_err));
  endtask

  // Advance one edge and move the model by the rules for the inputs currently applied.
  task automatic tick();
    logic [31:0] d [2];
    logic        b [2];
    for (int p = 0; p < 2; p++) view(1'b1, p, d[p], b[p]);
    @(posedge clk);
    if (!reset) begin
      for (int k = 0; k < 16; k++) m_regs[k] = 32'(k);
      m_busy = '0;
      m_err  = 1'b0;
      for (int p = 0; p < 2; p++) begin c_data[p] = '0; c_busy[p] = 1'b0; end
    end else begin
      m_err = wrEn && PROT[wrAddr];
      if (wrEn && !PROT[wrAddr]) begin
        m_regs[wrAddr] = wrData;
        m_busy[wrAddr] = 1'b0;
      end
      if (claimEn && !PROT[claimAddr]) m_busy[claimAddr] = 1'b1;
      for (int p = 0; p < 2; p++) begin c_data[p] = d[p]; c_busy[p] = b[p]; end
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) m_regs[k] = 32'hX;
    m_busy = 'x; m_err = 1'bx;
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd1, 32'h11, 1'b1, 4'd2);
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    tick();

    // Defaults after reset
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, 4'(15 - a), 4'(a), 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
      check_all();
      check("dflt0", rdData_a[31:0], 32'(a));
      check("dflt1", rdData_a[63:32], 32'(15 - a));
      tick();
    end

    // Bypass vs. no bypass
    drive(1'b1, 4'd0, 4'd3, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0);
    check_all();
    check("byp_hit", rdData_a[31:0], 32'hDEADBEEF);
    check("nobyp_old", rdData_b[31:0], 32'h3);
    tick();
    drive(1'b1, 4'd0, 4'd3, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    check_all();
    check("nobyp_new", rdData_b[31:0], 32'hDEADBEEF);
    check("regrd_byp", rdData_c[31:0], 32'hDEADBEEF);
    tick();

    // Claim then resolve r7
    drive(1'b1, 4'd0, 4'd7, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7);
    check_all();
    check("claim_same_cyc", 32'(rdBusy_a[0]), 32'h0);
    tick();
    drive(1'b1, 4'd0, 4'd7, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    check_all();
    check("busy7_rd", 32'(rdBusy_a[0]), 32'h1);
    check("busy7_vec", 32'(busyVec_a[7]), 32'h1);
    tick();
    drive(1'b1, 4'd0, 4'd7, 1'b1, 4'd7, 32'h77, 1'b0, 4'd0);
    check_all();
    check("wb7_busy", 32'(rdBusy_a[0]), 32'h0);
    check("wb7_data", rdData_a[31:0], 32'h77);
    tick();
    drive(1'b1, 4'd0, 4'd7, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    check_all();
    check("busy7_clr", 32'(busyVec_a[7]), 32'h0);
    tick();

    // Claim and write same register same edge
    drive(1'b1, 4'd0, 4'd0, 1'b1, 4'd9, 32'h99, 1'b1, 4'd9);
    check_all();
    tick();
    drive(1'b1, 4'd9, 4'd9, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    check_all();
    check("cw9_busy", 32'(busyVec_a[9]), 32'h1);
    check("cw9_data", rdData_a[31:0], 32'h99);
    check("same_addr", rdData_a[63:32], rdData_a[31:0]);
    tick();

    // Protected write and claim
    drive(1'b1, 4'd0, 4'd14, 1'b1, 4'd14, 32'h1234, 1'b0, 4'd0);
    check_all();
    check("prot_nobyp", rdData_a[31:0], 32'hE);
    tick();
    drive(1'b1, 4'd0, 4'd14, 1'b0, 4'd0, 32'h0, 1'b1, 4'd15);
    check_all();
    check("prot_err_hi", 32'(wrProtErr_a), 32'h1);
    check("prot_keep", rdData_a[31:0], 32'hE);
    tick();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    check_all();
    check("prot_err_lo", 32'(wrProtErr_a), 32'h0);
    check("prot_claim", 32'(busyVec_a[15]), 32'h0);
    tick();

    // Registered read latency
    drive(1'b1, 4'd2, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    check_all();
    tick();
    drive(1'b1, 4'd2, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    check_all();
    check("regrd_lat", rdData_c[63:32], 32'h2);
    tick();

    // Random traffic with occasional mid-stream reset
    for (int i = 0; i < 400; i++) begin
      logic [3:0] wa, ca;
      wa = ($urandom_range(0, 4) == 0) ? 4'(14 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
      ca = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ca = wa;
      drive(($urandom_range(0, 49) != 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 1), wa, $urandom, ($urandom_range(0, 4) < 2), ca);
      check_all();
      tick();
    end

    // Reset overriding pending claim and write
    drive(1'b1, 4'd1, 4'd5, 1'b0, 4'd0, 32'h0, 1'b1, 4'd5);
    tick();
    drive(1'b0, 4'd1, 4'd5, 1'b1, 4'd6, 32'hCAFE, 1'b1, 4'd4);
    tick();
    drive(1'b1, 4'd6, 4'd5, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    check_all();
    check("rst_busyvec", 32'(busyVec_a), 32'h0);
    check("rst_reg6", rdData_a[63:32], 32'h6);
    check("rst_regrd", rdData_c[31:0], 32'h0);
    check("rst_regrd_busy", 32'(rdBusy_c), 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised general-purpose register file for the pipelined core, generalising the fixed 16 x 32, two-read-port file with configurable width, depth and read-port count. Adds write-to-read bypass, a per-register busy scoreboard for hazard stalls, hardware-protected registers, and an optional registered read stage. It sits between decode (reads, destination claims) and writeback (writes).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 4, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of independent read ports (1..4)
- PROT_MASK, 16'hC000, bit k set = register k is write-protected (default r14, r15)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
- REG_RD, 0, 0 = combinational read; 1 = read data and busy registered (1-cycle latency)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- rdAddr  in  NUM_RD*ADDR_W  packed read addresses, port p at [p*ADDR_W +: ADDR_W]
- rdData  out  NUM_RD*DATA_W  packed read data, port p at [p*DATA_W +: DATA_W]
- rdBusy  out  NUM_RD  port p operand has an outstanding producer (stall request)
- wrEn  in  1  writeback write enable
- wrAddr  in  ADDR_W  writeback destination
- wrData  in  DATA_W  writeback data
- claimEn  in  1  decode marks claimAddr as having an in-flight producer
- claimAddr  in  ADDR_W  destination being claimed
- busyVec  out  2**ADDR_W  current scoreboard, bit k = register k busy
- wrProtErr  out  1  one-cycle pulse: previous cycle attempted write to protected register

## Operation
- Reset (reset==0 at rising edge): register k <= k zero-extended to DATA_W; busyVec <= 0; wrProtErr <= 0; if REG_RD=1, registered rdData <= 0 and rdBusy <= 0. Reset overrides wrEn and claimEn in the same cycle.
- Write: at rising edge with reset==1, wrEn==1 and PROT_MASK[wrAddr]==0 -> reg[wrAddr] <= wrData; busy[wrAddr] <= 0.
- Protected write: wrEn==1 with PROT_MASK[wrAddr]==1 -> storage and busy unchanged; wrProtErr==1 for the following cycle only.
- Claim: claimEn==1 and PROT_MASK[claimAddr]==0 -> busy[claimAddr] <= 1. Claims of protected registers ignored, no error.
- Claim and write same address same edge: claim wins, busy stays 1 (newer producer); data is still written.
- Claim and write different addresses: both apply independently.
- Read (per port p, combinational view): hit = BYPASS && wrEn && !PROT_MASK[wrAddr] && wrAddr==rdAddr_p. rdData_p = hit ? wrData : reg[rdAddr_p]. rdBusy_p = busy[rdAddr_p] && !hit.
- A same-cycle claim never affects the same cycle's rdBusy; visible next cycle.
- Multiple ports at the same address return identical data and busy.
- Out-of-range is impossible (full decode of 2**ADDR_W).

## Timing
- REG_RD=0: rdData/rdBusy combinational from rdAddr, wrEn/wrAddr/wrData and state; zero latency.
- REG_RD=1: rdData/rdBusy registered at rising edge from the combinational view above (bypass applied at sample time); valid one cycle after rdAddr presented.
- Writes, claims, busy clears: visible in storage/busyVec one cycle after the edge.
- BYPASS=0: a read of the register being written returns old value that cycle, new value next cycle.
- wrProtErr: asserted exactly one cycle after the offending edge; back-to-back violations keep it high continuously.
- busyVec: registered, no combinational path from inputs.

## Test plan
- Reset, then read all 16 regs on both ports (defaults) -> rdData == address (r5 reads 32'h5), busyVec == 0, wrProtErr == 0.
- wrEn=1, wrAddr=3, wrData=32'hDEADBEEF with rdAddr0=3, BYPASS=1 -> same-cycle rdData0 = 32'hDEADBEEF; BYPASS=0 -> 32'h3 that cycle, 32'hDEADBEEF next.
- claimEn r7; next cycle read r7 -> rdBusy0=1, busyVec[7]=1; write r7=32'h77 with rdAddr0=7 -> rdBusy0=0 and rdData0=32'h77 same cycle (BYPASS=1); busyVec[7]=0 after.
- Same edge claim r9 and write r9=32'h99 -> busyVec[9]=1, reg9=32'h99.
- Write r14=32'h1234 -> r14 still reads 32'hE, wrProtErr high exactly one cycle; claim r15 -> busyVec[15] stays 0.
- REG_RD=1: change rdAddr1 to 2 -> rdData1=32'h2 one cycle later; assert reset (low) mid-stream with pending claims and wrEn -> next cycle all regs default, busyVec=0, rdData=0.
